drive_sequencer: RTL and testbench



---
 rtl/drive_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_drive_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Drive-stage sequencer: maps the line sensor to a motor mode and a PWM duty.
// It forces a stop dead-time between direction changes, soft-starts the duty and flags a lost line.
module drive_sequencer #(
    parameter int unsigned DEAD_CYCLES  = 100_000,
    parameter int unsigned RAMP_DIV     = 10_000,
    parameter int unsigned RAMP_STEP    = 8,
    parameter int unsigned DUTY_MIN     = 600,
    parameter int unsigned DUTY_MAX     = 760,
    parameter int unsigned LOST_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] sensor,
    output logic [1:0] mode,
    output logic [9:0] duty,
    output logic       lost,
    output logic [1:0] state
);

    // state | meaning
    // IDLE  | not enabled or no line seen yet; motors stopped
    // RUN   | driving toward the current target, duty ramping
    // DEAD  | stopped for the dead-time before a new heading
    // LOST  | line missing too long; stopped until a line reappears
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10,
        ST_LOST = 2'b11
    } state_t;

    localparam logic [1:0]  MODE_LEFT   = 2'b00;
    localparam logic [1:0]  MODE_STRT   = 2'b01;
    localparam logic [1:0]  MODE_RIGHT  = 2'b10;
    localparam logic [1:0]  MODE_STOP   = 2'b11;
    localparam logic [9:0]  DUTY_MIN10  = 10'(DUTY_MIN);
    localparam logic [9:0]  DUTY_MAX10  = 10'(DUTY_MAX);
    localparam logic [10:0] DUTY_MAX11  = {1'b0, DUTY_MAX10};
    localparam logic [10:0] STEP11      = 11'(RAMP_STEP);
    localparam logic [31:0] RAMP_LAST   = 32'(RAMP_DIV - 1);
    localparam logic [31:0] DEAD_LAST   = 32'(DEAD_CYCLES - 1);
    localparam logic [31:0] LOST_LAST   = 32'(LOST_TIMEOUT - 1);

    logic [2:0]  s1, s2;
    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [9:0]  duty_q, duty_d;
    logic [1:0]  pending_q, pending_d;
    logic [31:0] ramp_cnt_q, ramp_cnt_d;
    logic [31:0] dead_cnt_q, dead_cnt_d;
    logic [31:0] lost_cnt_q, lost_cnt_d;

    logic        tgt_valid;
    logic [1:0]  tgt;
    logic [1:0]  pend_next;
    logic [10:0] duty_sum;
    logic [9:0]  duty_ramped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 3'b000;
            s2 <= 3'b000;
        end else begin
            s1 <= sensor;
            s2 <= s1;
        end
    end

    always_comb begin
        tgt_valid = 1'b1;
        tgt       = MODE_STRT;
        case (s2)
            3'b100, 3'b110: tgt = MODE_LEFT;
            3'b001, 3'b011: tgt = MODE_RIGHT;
            3'b000: begin
                tgt_valid = 1'b0;
                tgt       = MODE_STOP;
            end
            default: tgt = MODE_STRT;
        endcase
    end

    // Widened to 11 bits so a ceiling near 1023 cannot wrap the sum.
    always_comb begin
        duty_sum    = {1'b0, duty_q} + STEP11;
        duty_ramped = (duty_sum > DUTY_MAX11) ? DUTY_MAX10 : duty_sum[9:0];
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        duty_d     = duty_q;
        pending_d  = pending_q;
        ramp_cnt_d = ramp_cnt_q;
        dead_cnt_d = dead_cnt_q;
        lost_cnt_d = lost_cnt_q;
        pend_next  = tgt_valid ? tgt : pending_q;

        if (!enable) begin
            state_d    = ST_IDLE;
            mode_d     = MODE_STOP;
            duty_d     = 10'd0;
            pending_d  = MODE_STOP;
            ramp_cnt_d = 32'd0;
            dead_cnt_d = 32'd0;
            lost_cnt_d = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOST: begin
                    if (tgt_valid) begin
                        state_d    = ST_RUN;
                        mode_d     = tgt;
                        duty_d     = DUTY_MIN10;
                        ramp_cnt_d = 32'd0;
                        dead_cnt_d = 32'd0;
                        lost_cnt_d = 32'd0;
                    end
                end
                ST_RUN: begin
                    if (tgt_valid && (tgt != mode_q)) begin
                        state_d    = ST_DEAD;
                        mode_d     = MODE_STOP;
                        duty_d     = 10'd0;
                        pending_d  = tgt;
                        ramp_cnt_d = 32'd0;
                        dead_cnt_d = 32'd0;
                        lost_cnt_d = 32'd0;
                    end else if (tgt_valid) begin
                        lost_cnt_d = 32'd0;
                        if (ramp_cnt_q == RAMP_LAST) begin
                            ramp_cnt_d = 32'd0;
                            duty_d     = duty_ramped;
                        end else begin
                            ramp_cnt_d = ramp_cnt_q + 32'd1;
                        end
                    end else if (lost_cnt_q == LOST_LAST) begin
                        state_d    = ST_LOST;
                        mode_d     = MODE_STOP;
                        duty_d     = 10'd0;
                        ramp_cnt_d = 32'd0;
                        lost_cnt_d = 32'd0;
                    end else begin
                        // Searching on the last heading: mode, duty and ramp all frozen.
                        lost_cnt_d = lost_cnt_q + 32'd1;
                    end
                end
                ST_DEAD: begin
                    pending_d = pend_next;
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d    = ST_RUN;
                        mode_d     = pend_next;
                        duty_d     = DUTY_MIN10;
                        dead_cnt_d = 32'd0;
                        ramp_cnt_d = 32'd0;
                        lost_cnt_d = 32'd0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 32'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_STOP;
            duty_q     <= 10'd0;
            pending_q  <= MODE_STOP;
            ramp_cnt_q <= 32'd0;
            dead_cnt_q <= 32'd0;
            lost_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            duty_q     <= duty_d;
            pending_q  <= pending_d;
            ramp_cnt_q <= ramp_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign mode  = mode_q;
    assign duty  = duty_q;
    assign state = state_q;
    assign lost  = (state_q == ST_LOST);

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboard bench for drive_sequencer with small timing parameters.
// Expected outputs are queued against the cycle they are due and checked on the falling edge.
module tb_drive_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] sensor;
    logic [1:0] mode;
    logic [9:0] duty;
    logic       lost;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int          due_q[$];
    string       tag_q[$];
    logic [15:0] exp_q[$];

    drive_sequencer #(
        .DEAD_CYCLES (4),
        .RAMP_DIV    (3),
        .RAMP_STEP   (8),
        .DUTY_MIN    (600),
        .DUTY_MAX    (616),
        .LOST_TIMEOUT(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .sensor(sensor),
        .mode  (mode),
        .duty  (duty),
        .lost  (lost),
        .state (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pack(input logic [1:0] m, input logic [9:0] d,
                                         input logic [1:0] st, input logic l);
        return {1'b0, l, st, m, d};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got mode=%b duty=%0d state=%b lost=%b, want mode=%b duty=%0d state=%b lost=%b",
                     tag, got[11:10], got[9:0], got[13:12], got[14],
                     want[11:10], want[9:0], want[13:12], want[14]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int off, input string tag, input logic [1:0] m,
                             input int d, input logic [1:0] st);
        due_q.push_back(cyc + off);
        tag_q.push_back(tag);
        exp_q.push_back(pack(m, 10'(d), st, st == 2'b11));
    endtask

    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            check_val(tag_q.pop_front(), pack(mode, duty, state, lost), exp_q.pop_front());
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sensor = 3'b000;
        #12;
        check_val("reset_vals", pack(mode, duty, state, lost), pack(2'b11, 10'd0, 2'b00, 1'b0));
        @(negedge clk);
        reset = 1'b0;
        tick(2);

        // start-up and soft-start ramp to saturation
        enable = 1'b1;
        sensor = 3'b010;
        expect_at(1,  "su_idle_a",  2'b11, 0,   2'b00);
        expect_at(2,  "su_idle_b",  2'b11, 0,   2'b00);
        expect_at(3,  "su_run",     2'b01, 600, 2'b01);
        expect_at(5,  "su_min",     2'b01, 600, 2'b01);
        expect_at(6,  "su_step1",   2'b01, 608, 2'b01);
        expect_at(8,  "su_step1_h", 2'b01, 608, 2'b01);
        expect_at(9,  "su_step2",   2'b01, 616, 2'b01);
        expect_at(12, "su_sat",     2'b01, 616, 2'b01);
        expect_at(15, "su_sat2",    2'b01, 616, 2'b01);
        tick(15);

        // straight -> left with dead-time
        sensor = 3'b100;
        expect_at(2,  "turn_pre",   2'b01, 616, 2'b01);
        expect_at(3,  "turn_dead0", 2'b11, 0,   2'b10);
        expect_at(6,  "turn_dead3", 2'b11, 0,   2'b10);
        expect_at(7,  "turn_left",  2'b00, 600, 2'b01);
        expect_at(9,  "turn_min",   2'b00, 600, 2'b01);
        expect_at(10, "turn_step",  2'b00, 608, 2'b01);
        tick(10);

        // retarget during DEAD: last valid target wins, dead-time unchanged
        sensor = 3'b010;
        expect_at(3,  "rt_dead0",   2'b11, 0,   2'b10);
        expect_at(6,  "rt_dead3",   2'b11, 0,   2'b10);
        expect_at(7,  "rt_right",   2'b10, 600, 2'b01);
        expect_at(10, "rt_step",    2'b10, 608, 2'b01);
        tick(1);
        sensor = 3'b001;
        tick(9);

        sensor = 3'b010;
        expect_at(3,  "rt2_dead0",  2'b11, 0,   2'b10);
        expect_at(6,  "rt2_dead3",  2'b11, 0,   2'b10);
        expect_at(7,  "rt2_strt",   2'b01, 600, 2'b01);
        tick(1);
        sensor = 3'b100;
        tick(1);
        sensor = 3'b010;
        tick(6);

        // back to left, then 9 cycles of no line: heading held, no LOST
        sensor = 3'b100;
        expect_at(3,  "l9_dead",    2'b11, 0,   2'b10);
        expect_at(7,  "l9_left",    2'b00, 600, 2'b01);
        tick(8);
        sensor = 3'b000;
        expect_at(7,  "l9_search",  2'b00, 608, 2'b01);
        expect_at(11, "l9_hold",    2'b00, 608, 2'b01);
        expect_at(12, "l9_dead",    2'b11, 0,   2'b10);
        expect_at(16, "l9_strt",    2'b01, 600, 2'b01);
        tick(9);
        sensor = 3'b010;
        tick(7);

        // 10 cycles of no line -> LOST, then recovery without dead-time
        sensor = 3'b000;
        expect_at(11, "l10_pre",    2'b01, 600, 2'b01);
        expect_at(12, "l10_lost",   2'b11, 0,   2'b11);
        expect_at(16, "l10_hold",   2'b11, 0,   2'b11);
        expect_at(17, "l10_exit",   2'b10, 600, 2'b01);
        tick(14);
        sensor = 3'b001;
        tick(4);

        // enable drop mid-DEAD, then idle while sensor is 000
        sensor = 3'b010;
        expect_at(4,  "en_dead",    2'b11, 0,   2'b10);
        expect_at(5,  "en_idle",    2'b11, 0,   2'b00);
        tick(4);
        enable = 1'b0;
        tick(1);
        sensor = 3'b000;
        tick(3);
        enable = 1'b1;
        expect_at(2,  "en_wait_a",  2'b11, 0,   2'b00);
        expect_at(4,  "en_wait_b",  2'b11, 0,   2'b00);
        tick(4);
        sensor = 3'b001;
        expect_at(2,  "en_wait_c",  2'b11, 0,   2'b00);
        expect_at(3,  "en_run",     2'b10, 600, 2'b01);
        expect_at(6,  "rst_pre",    2'b10, 608, 2'b01);
        tick(7);

        // asynchronous reset mid-ramp, away from any clock edge
        #3;
        reset = 1'b1;
        #1;
        check_val("async_rst", pack(mode, duty, state, lost), pack(2'b11, 10'd0, 2'b00, 1'b0));
        @(negedge clk);
        reset = 1'b0;
        expect_at(1,  "post_rst_a", 2'b11, 0,   2'b00);
        expect_at(2,  "post_rst_b", 2'b11, 0,   2'b00);
        expect_at(3,  "post_rst_run", 2'b10, 600, 2'b01);
        tick(5);

        while (due_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: never checked, was due at cycle %0d", tag_q.pop_front(), due_q.pop_front());
            void'(exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
